// File: rtl/matmul_feed_ctrl_pkg.sv
// Purpose: shared types and constants for the systolic matmul feed controller.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents: minifloat field layout (1 sign, 3 exponent, 4 fraction bits),
// the minifloat zero, FSM state enum, step counter width, parameter defaults.
package matmul_pkg;

    localparam int MF_SIGN     = 7;
    localparam int MF_EXP_W    = 3;
    localparam int MF_EXP_LSB  = 4;
    localparam int MF_FRAC_W   = 4;
    localparam int MF_FRAC_LSB = 0;

    // All-zero encoding; a PE treats it as "no contribution".
    localparam logic [7:0] MF_ZERO = 8'h00;

    localparam int N_DEFAULT         = 4;
    localparam int DW_DEFAULT        = 8;
    localparam int DRAIN_CYC_DEFAULT = 2;

    // Shared FEED step / DRAIN counter. Largest value is max(2*8-2, 15-1) = 14.
    localparam int STEP_W = 4;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        FEED,
        DRAIN,
        DONE
    } state_e;

    function automatic logic mf_is_zero(input logic [7:0] x);
        return (x[MF_EXP_LSB +: MF_EXP_W] == '0) &&
               (x[MF_FRAC_LSB +: MF_FRAC_W] == '0);
    endfunction

endpackage

// File: rtl/matmul_feed_ctrl_if.sv
// Purpose: bundles the load port, run control and array feed bus of the controller.
// Latency: n/a (wiring only).
// Backpressure: load_ready gates writes; requester holds load_valid until accepted.
//
// master: host side (drives load_* and start, observes status and feed bus).
// slave : matmul_feed_ctrl (accepts loads, drives status and feed bus).
interface matmul_feed_ctrl_if #(
    parameter int N  = 4,
    parameter int DW = 8
);
    localparam int IW = $clog2(N);

    logic          load_valid;
    logic          load_ready;
    logic          load_sel;
    logic [IW-1:0] load_row;
    logic [IW-1:0] load_col;
    logic [DW-1:0] load_data;
    logic          start;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic          feed_valid;
    logic [N*DW-1:0] row_data;
    logic [N*DW-1:0] col_data;

    modport master (
        output load_valid, load_sel, load_row, load_col, load_data, start,
        input  load_ready, busy, done, acc_clr, feed_valid, row_data, col_data
    );

    modport slave (
        input  load_valid, load_sel, load_row, load_col, load_data, start,
        output load_ready, busy, done, acc_clr, feed_valid, row_data, col_data
    );

endinterface

// File: rtl/matmul_skew_mux.sv
// Purpose: per-lane skewed operand select for one edge of the systolic array.
// Latency: combinational; caller registers the result.
// Backpressure: none.
//
// Ports: mat_i  - N*N matrix, element (r,c) at bits (r*N+c)*DW +: DW
//        t_i    - FEED step
//        lane_o - lane l = element at index k = t-l along the operand's inner
//                 dimension: A[l][k] (COL_MODE=0) or B[k][l] (COL_MODE=1), else zero
module matmul_skew_mux
    import matmul_pkg::*;
#(
    parameter int N        = N_DEFAULT,
    parameter int DW       = DW_DEFAULT,
    parameter bit COL_MODE = 1'b0
) (
    input  logic [N*N*DW-1:0] mat_i,
    input  logic [STEP_W-1:0] t_i,
    output logic [N*DW-1:0]   lane_o
);

    // Lane l carries inner index k exactly when t == l + k; at most one k matches.
    always_comb begin
        lane_o = '0;
        for (int l = 0; l < N; l++) begin
            lane_o[l*DW +: DW] = DW'(MF_ZERO);
            for (int k = 0; k < N; k++) begin
                if (t_i == STEP_W'(l + k)) begin
                    if (COL_MODE)
                        lane_o[l*DW +: DW] = mat_i[(k*N + l)*DW +: DW];
                    else
                        lane_o[l*DW +: DW] = mat_i[(l*N + k)*DW +: DW];
                end
            end
        end
    end

endmodule

// File: rtl/matmul_feed_ctrl.sv
// Purpose: buffers A/B and feeds an NxN systolic array with skewed operands.
// Latency: start -> done = 2N+DRAIN_CYC cycles (one less without the CLEAR state).
// Backpressure: load_ready high only in IDLE; start ignored (not queued) outside IDLE.
//
// Ports: clk, rst_n (async active-low); bus (matmul_feed_ctrl_if.slave):
//   load_valid/load_ready/load_sel/load_row/load_col/load_data - element writes
//   start, busy, done, acc_clr - run control; feed_valid, row_data, col_data - array feed
// Optional feature macro: MATMUL_ACC_CLR_EN (CLEAR state + acc_clr pulse per run).
module matmul_feed_ctrl
    import matmul_pkg::*;
#(
    parameter int N         = N_DEFAULT,
    parameter int DW        = DW_DEFAULT,
    parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    matmul_feed_ctrl_if.slave  bus
);

    localparam int IW = $clog2(N);
    localparam int MW = N*N*DW;
    localparam logic [STEP_W-1:0] FEED_LAST  = STEP_W'(2*N - 2);
    localparam logic [STEP_W-1:0] DRAIN_LAST = STEP_W'(DRAIN_CYC - 1);

    state_e            state_q, state_d;
    logic [STEP_W-1:0] cnt_q, cnt_d;
    logic              load_ready;
    logic              wr_en;

    logic [MW-1:0]     abuf_q, abuf_d;
    logic [MW-1:0]     bbuf_q, bbuf_d;
    logic [N*DW-1:0]   row_mux, col_mux;

    logic              feed_valid_q;
    logic              done_q;
    logic [N*DW-1:0]   row_data_q, col_data_q;

    assign load_ready     = (state_q == IDLE);
    assign wr_en          = bus.load_valid && load_ready;
    assign bus.load_ready = load_ready;
    assign bus.busy       = (state_q != IDLE);

    // Next buffer contents. Indices >= N match no slot, so they are dropped.
    // The skew muxes read these next values so that a write landing on the
    // start edge is already visible to the first feed step.
    always_comb begin
        abuf_d = abuf_q;
        bbuf_d = bbuf_q;
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                if (wr_en && bus.load_row == IW'(r) && bus.load_col == IW'(c)) begin
                    if (bus.load_sel)
                        bbuf_d[(r*N + c)*DW +: DW] = bus.load_data;
                    else
                        abuf_d[(r*N + c)*DW +: DW] = bus.load_data;
                end
            end
        end
    end

    // Operand storage is deliberately not reset.
    always_ff @(posedge clk) begin
        abuf_q <= abuf_d;
        bbuf_q <= bbuf_d;
    end

    // cnt is the FEED step t, then reused as the DRAIN cycle count.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
`ifdef MATMUL_ACC_CLR_EN
                    state_d = CLEAR;
`else
                    state_d = FEED;
`endif
                    cnt_d = '0;
                end
            end
            CLEAR: begin
                state_d = FEED;
                cnt_d   = '0;
            end
            FEED: begin
                if (cnt_q == FEED_LAST) begin
                    state_d = DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + STEP_W'(1);
                end
            end
            DRAIN: begin
                if (cnt_q == DRAIN_LAST) begin
                    state_d = DONE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + STEP_W'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    matmul_skew_mux #(.N(N), .DW(DW), .COL_MODE(1'b0)) u_row_skew (
        .mat_i  (abuf_d),
        .t_i    (cnt_d),
        .lane_o (row_mux)
    );

    matmul_skew_mux #(.N(N), .DW(DW), .COL_MODE(1'b1)) u_col_skew (
        .mat_i  (bbuf_d),
        .t_i    (cnt_d),
        .lane_o (col_mux)
    );

    // Outputs are registered from the next state, so each one lines up with
    // the state the FSM occupies during that cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            feed_valid_q <= 1'b0;
            done_q       <= 1'b0;
            row_data_q   <= '0;
            col_data_q   <= '0;
        end else begin
            feed_valid_q <= (state_d == FEED);
            done_q       <= (state_d == DONE);
            row_data_q   <= (state_d == FEED) ? row_mux : '0;
            col_data_q   <= (state_d == FEED) ? col_mux : '0;
        end
    end

`ifdef MATMUL_ACC_CLR_EN
    logic acc_clr_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_clr_q <= 1'b0;
        else
            acc_clr_q <= (state_d == CLEAR);
    end

    assign bus.acc_clr = acc_clr_q;
`else
    // Without the clear, successive runs accumulate into the PEs (C += A*B).
    assign bus.acc_clr = 1'b0;
`endif

    assign bus.feed_valid = feed_valid_q;
    assign bus.done       = done_q;
    assign bus.row_data   = row_data_q;
    assign bus.col_data   = col_data_q;

endmodule

// File: doc/matmul_feed_ctrl.md
# matmul_feed_ctrl

Sequencing controller for the N×N systolic array of `mac_unit` processing elements in the matrix multiplier. It buffers operand matrices A and B, which are written one 8-bit minifloat element at a time. On `start` it clears the PE accumulators and drives the array's left-edge rows and top-edge columns with correctly skewed operands. It waits for the pipeline to drain, then pulses `done`.

## Interface
Parameters:
- `N`, default 4, array dimension (matrices are N×N); legal range 2..8.
- `DW`, default 8, element width (minifloat: 1 sign, 3 exponent, 4 fraction bits).
- `DRAIN_CYC`, default 2, idle cycles after the last feed, covering PE registering latency; legal range 1..15.

Ports:
- `clk` in 1 — single clock, all logic on rising edge.
- `rst_n` in 1 — asynchronous, active-low reset.
- `load_valid` in 1 — write request for one buffer element.
- `load_ready` out 1 — write accepted when high; high only in IDLE.
- `load_sel` in 1 — target buffer: 0 = A, 1 = B.
- `load_row` in clog2(N) — row index of the element.
- `load_col` in clog2(N) — column index of the element.
- `load_data` in DW — element value.
- `start` in 1 — begin a multiply; sampled only in IDLE.
- `busy` out 1 — high whenever state ≠ IDLE.
- `done` out 1 — one-cycle pulse at the end of a run.
- `acc_clr` out 1 — one-cycle accumulator clear to all PEs.
- `feed_valid` out 1 — high during feed cycles.
- `row_data` out N*DW — lane i (bits i*DW +: DW) drives the `a` input of PE(i,0).
- `col_data` out N*DW — lane j drives the `b` input of PE(0,j).

## Operation
- Two N×N register buffers, `abuf` and `bbuf`. A write occurs when `load_valid && load_ready`.
- Reset does not clear `abuf` or `bbuf`.
- FSM states and transitions:
  - IDLE → CLEAR when `start` is high.
  - CLEAR lasts 1 cycle, with `acc_clr` = 1. It then goes to FEED.
  - FEED lasts 2N−1 cycles, counted by step counter t = 0..2N−2.
  - DRAIN lasts `DRAIN_CYC` cycles.
  - DONE lasts 1 cycle, with `done` = 1. It then returns to IDLE.
- Skew rule at FEED step t:
  - `row_data` lane i = A[i][t−i] when 0 ≤ t−i < N; otherwise 0.
  - `col_data` lane j = B[t−j][j] when 0 ≤ t−j < N; otherwise 0.
  - The value 0 is the minifloat zero, which a PE treats as no contribution.
- Outside FEED, `row_data`, `col_data` and `feed_valid` are 0.
- Simultaneous `load_valid` and `start` in IDLE: the write completes on that edge and start is accepted on the same edge. The written value is used in the run.
- `start` outside IDLE is ignored; it is not queued.
- `load_valid` outside IDLE is not accepted (`load_ready` = 0). The requester must hold the request.
- Out-of-range indices (≥ N, possible when N is not a power of 2) are discarded with no write.

## Timing
- Reset (asynchronous assert):
  - state = IDLE, t = 0.
  - `busy`, `done`, `acc_clr`, `feed_valid`, `row_data`, `col_data` = 0.
  - `load_ready` = 1.
- Reset asserted mid-run aborts immediately to IDLE. No `done` is produced.
- All outputs are registered, except `load_ready` and `busy`, which are decoded from the state register.
- Timeline with start sampled at edge E0:
  - `acc_clr` is high E0–E1.
  - `feed_valid` is high E1 through E(2N).
  - DRAIN occupies the next `DRAIN_CYC` cycles.
  - `done` is high for the cycle beginning at E(2N+DRAIN_CYC).
- Total `busy` time = 2N + 1 + DRAIN_CYC cycles (N=4, DRAIN_CYC=2: 11 cycles).
- A new `start` can be accepted on the edge after DONE, giving back-to-back runs with one IDLE cycle between them.

## Configuration
- `MATMUL_ACC_CLR_EN`:
  - Defined: CLEAR state present and `acc_clr` pulses as above.
  - Undefined: CLEAR is skipped (IDLE → FEED on start) and `acc_clr` is tied to 0. Successive runs accumulate into the PE results (C += A·B), and all latencies shrink by 1 cycle.

## Structure
- Shared package `matmul_pkg`: minifloat field widths and offsets (`MF_SIGN`, `MF_EXP_W` = 3, `MF_FRAC_W` = 4), `MF_ZERO` = 8'h00, FSM state enum (IDLE, CLEAR, FEED, DRAIN, DONE), and the default for `N`.
- One sub-module: `matmul_skew_mux`, the combinational per-lane selection of A[i][t−i] / B[t−j][j] or zero. It is instantiated once for rows and once for columns; its outputs are registered in the controller.

## Test plan
- Load/skew: N=4, load A[i][k] = {i,k} nibbles, start → at FEED t=3, `row_data` lanes 0..3 = 8'h03, 8'h12, 8'h21, 8'h30. At t=0 only lane 0 = 8'h00 (A[0][0]) and lanes 1..3 = 0.
- Column skew: B[k][j] = {k,j} → at FEED t=6, col lane 3 = 8'h33 and lanes 0..2 = 0.
- Timing: start at E0 with N=4, DRAIN_CYC=2 → `acc_clr` for 1 cycle, `feed_valid` for 7 cycles, `done` one cycle at E10, `busy` for 11 cycles.
- Handshake: `load_valid` during FEED → `load_ready` = 0 and buffer unchanged. Same-cycle load A[0][0]=8'h3C plus start → first `row_data` lane 0 = 8'h3C.
- Abort: deassert `rst_n` at FEED t=2 → all outputs 0 immediately, no `done`. After release, a new start produces the full timeline.
- Full product with 2×2 PE model: A = B = identity (1.0 = 8'h30 on the diagonal) → result C equals the identity after `done`. Without `MATMUL_ACC_CLR_EN`, a second run yields 2·I.
